// File: rtl/vram_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the screen RAM arbiter.
// The arbiter states and the video phase window check live here.
package vram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int VID_FIRST_DEF     = 10;
   localparam int VID_LAST_DEF      = 14;
   localparam int SCREEN_PAGE_BYTES = 8192;

   function automatic logic in_vid_window(input logic [3:0] phase,
                                          input int         first,
                                          input int         last);
      return (int'(phase) >= first) && (int'(phase) <= last);
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
`timescale 1ns/1ps
// Z80-side request bus into the screen RAM arbiter.
// Handshake: cpu_req stays high with stable we/addr/wdata until the one-cycle cpu_ack; cpu_wait is high while the request is pending.
interface vram_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_wait;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_wait
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_wait
   );

endinterface

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// Screen RAM arbiter: video owns character phases VID_FIRST..VID_LAST,
// the Z80 side is served in the remaining phases through a wait/ack handshake.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int VID_ADDR_W = 13,
   parameter int VID_FIRST  = VID_FIRST_DEF,
   parameter int VID_LAST   = VID_LAST_DEF
) (
   input  logic                  clk_pix,
   input  logic                  reset,
   input  logic [3:0]            vid_phase,
   input  logic                  vid_page,
   input  logic [VID_ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0]     vid_data,
   vram_arbiter_if.slave         cpu,
   output logic [VID_ADDR_W:0]   ram_addr,
   output logic                  ram_we,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_q,
   output state_t                o_dbg_state
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_we;
   logic [VID_ADDR_W:0]   r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic                  w_vid_win;
   logic                  w_cpu_slot;
   logic                  w_rd_done;

   assign w_vid_win  = in_vid_window(vid_phase, VID_FIRST, VID_LAST);
   // Reset gates the slot so a write pending in ISSUE never reaches the RAM.
   assign w_cpu_slot = (r_state == ISSUE) && !w_vid_win && !reset;
   assign w_rd_done  = (r_state == DONE) && !r_we;

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) && cpu.cpu_req) begin
            r_we    <= cpu.cpu_we;
            r_addr  <= cpu.cpu_addr;
            r_wdata <= cpu.cpu_wdata;
         end
         if (w_rd_done) begin
            r_rdata <= ram_q;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (cpu.cpu_req) w_state_nxt = ISSUE;
         ISSUE:   if (!w_vid_win)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ram_addr  = w_cpu_slot ? r_addr : {vid_page, vid_addr};
   assign ram_we    = w_cpu_slot && r_we;
   assign ram_wdata = r_wdata;

   // The synchronous RAM returns read data during DONE; it is passed through
   // for the ack cycle and held in r_rdata from then on.
   assign cpu.cpu_rdata = w_rd_done ? ram_q : r_rdata;
   assign cpu.cpu_ack   = (r_state == DONE) && !reset;
   assign cpu.cpu_wait  = !reset && (((r_state == IDLE) && cpu.cpu_req) || (r_state == ISSUE));

   assign vid_data    = ram_q;
   assign o_dbg_state = r_state;

endmodule
